// File: rtl/parallel_serializer.sv
// Parallel-in, serial-out transmit stage feeding the 6-bit serial shift-register family.
// Latency: first bit on sout the cycle after the accepting edge; done one cycle after the last frame bit.
// Backpressure: ready is low for the whole frame; load is ignored while ready=0.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   clr    - asynchronous active-high reset; aborts a frame without producing done
//   din    - parallel word, sampled only on the accepting edge
//   load   - frame request, accepted on any edge where load && ready
//   dir    - bit order sampled with din: 0 = LSB first, 1 = MSB first
//   ready  - high while idle
//   sout   - serial data bit (drives the downstream register's data input)
//   sframe - high while sout carries a valid frame bit
//   done   - one-cycle pulse after the last frame bit
//
// Build option: define SERIALIZER_PARITY_EN to append an even-parity bit to every frame.

module parallel_serializer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  input  logic             dir,
  output logic             ready,
  output logic             sout,
  output logic             sframe,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
  logic par_q;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             dir_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      shreg  <= '0;
      cnt    <= '0;
      dir_q  <= 1'b0;
      sout   <= 1'b0;
      sframe <= 1'b0;
      ready  <= 1'b1;
      done   <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // ready is always 1 here, so load alone qualifies acceptance
          if (load) begin
            shreg  <= din;
            dir_q  <= dir;
            cnt    <= '0;
            sout   <= dir ? din[WIDTH-1] : din[0];
            sframe <= 1'b1;
            ready  <= 1'b0;
            state  <= SHIFT;
`ifdef SERIALIZER_PARITY_EN
            par_q  <= ^din;
`endif
          end
        end

        SHIFT: begin
          if (cnt == LAST) begin
`ifdef SERIALIZER_PARITY_EN
            sout  <= par_q;
            state <= PAR;
`else
            sout   <= 1'b0;
            sframe <= 1'b0;
            ready  <= 1'b1;
            done   <= 1'b1;
            state  <= IDLE;
`endif
          end else begin
            cnt <= cnt + 1'b1;
            // The bit currently on sout sits at the end of shreg; present its
            // neighbour next and move the word one place toward that end.
            if (dir_q) begin
              sout  <= shreg[WIDTH-2];
              shreg <= {shreg[WIDTH-2:0], 1'b0};
            end else begin
              sout  <= shreg[1];
              shreg <= {1'b0, shreg[WIDTH-1:1]};
            end
          end
        end

`ifdef SERIALIZER_PARITY_EN
        PAR: begin
          sout   <= 1'b0;
          sframe <= 1'b0;
          ready  <= 1'b1;
          done   <= 1'b1;
          state  <= IDLE;
        end
`endif

        default: begin
          sout   <= 1'b0;
          sframe <= 1'b0;
          ready  <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_serializer.sv
// Bench for parallel_serializer: scoreboard of expected frames checked bit by bit
// on sout, plus a behavioural serial-to-parallel register checked at each done.
// Directed cases cover bit order, mid-frame load, async clear and back-to-back frames.

module tb_parallel_serializer;

  localparam int W = 6;
`ifdef SERIALIZER_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk;
  logic         clr;
  logic [W-1:0] din;
  logic         load;
  logic         dir;
  logic         ready;
  logic         sout;
  logic         sframe;
  logic         done;

  parallel_serializer #(.WIDTH(W)) dut (
    .clk    (clk),
    .clr    (clr),
    .din    (din),
    .load   (load),
    .dir    (dir),
    .ready  (ready),
    .sout   (sout),
    .sframe (sframe),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [FL-1:0] bits;      // bits[i] is the i-th bit on the line
    logic [W-1:0]  word_ord;  // word as it should appear in the serial-to-parallel register
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   bit_idx  = 0;
  int   n_frames = 0;
  int   n_pushed = 0;

  task automatic push_exp(input logic [W-1:0] word, input logic d);
    exp_t e;
    e.bits = '0;
    for (int i = 0; i < W; i++)
      e.bits[i] = d ? word[W-1-i] : word[i];
`ifdef SERIALIZER_PARITY_EN
    e.bits[W] = ^word;
`endif
    for (int i = 0; i < W; i++)
      e.word_ord[W-1-i] = e.bits[i];
    exp_q.push_back(e);
    n_pushed++;
  endtask

  // Downstream serial-to-parallel register: first bit received ends up at the MSB.
  logic [FL-1:0] sipo;
  always @(posedge clk or posedge clr) begin
    if (clr)
      sipo <= '0;
    else if (sframe)
      sipo <= {sipo[FL-2:0], sout};
  end

  // Monitor: pop a scoreboard entry at each frame start, compare every bit.
  always @(negedge clk) begin
    if (clr) begin
      bit_idx = 0;
    end else begin
      check("ready_vs_sframe", ready, !sframe);
      if (!sframe)
        check("sout_idle", sout, 1'b0);
      if (sframe) begin
        if (bit_idx == 0) begin
          if (exp_q.size() == 0)
            check("sb_underflow", 1, 0);
          else
            cur = exp_q.pop_front();
        end
        if (bit_idx < FL)
          check("sout_bit", sout, cur.bits[bit_idx]);
        else
          check("frame_overrun", bit_idx, FL - 1);
        bit_idx++;
      end
      if (done) begin
        check("done_len", bit_idx, FL);
        check("done_ready", ready, 1'b1);
        check("done_sframe", sframe, 1'b0);
        check("sipo_word", sipo[FL-1 -: W], cur.word_ord);
        bit_idx = 0;
        n_frames++;
      end
    end
  end

  // One frame with bounded wait for done; poke>=0 pulses load with all-ones mid-frame.
  task automatic send(input logic [W-1:0] word, input logic d, input int poke);
    int n;
    @(negedge clk);
    check("ready_before_load", ready, 1'b1);
    din  = word;
    dir  = d;
    load = 1'b1;
    push_exp(word, d);
    @(posedge clk);
    n = 0;
    @(negedge clk);
    load = 1'b0;
    din  = W'($urandom);
    dir  = ~d;
    while (!done && n < FL + 4) begin
      check("ready_busy", ready, 1'b0);
      if (n == poke) begin
        load = 1'b1;
        din  = '1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    load = 1'b0;
    check("done_latency", n, FL);
  endtask

  logic [W-1:0] alt [2];

  initial begin
    clr  = 1'b1;
    din  = '0;
    load = 1'b0;
    dir  = 1'b0;
    #1;
    check("rst_sout", sout, 1'b0);
    check("rst_sframe", sframe, 1'b0);
    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    repeat (2) @(negedge clk);
    clr = 1'b0;

    // Bit order and parity words
    send(6'b101100, 1'b1, -1);
    send(6'b101100, 1'b0, -1);
    send(6'b110000, 1'b1, -1);

    // Load pulsed mid-frame must be ignored
    send(6'b101100, 1'b1, 1);
    repeat (3) begin
      @(negedge clk);
      check("no_restart", sframe, 1'b0);
    end

    // Async clear mid-frame after E2
    @(negedge clk);
    din  = 6'b011010;
    dir  = 1'b0;
    load = 1'b1;
    push_exp(din, dir);
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 clr = 1'b1;
    #1;
    check("clr_sout", sout, 1'b0);
    check("clr_sframe", sframe, 1'b0);
    check("clr_ready", ready, 1'b1);
    check("clr_done", done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("no_done_after_clr", done, 1'b0);
    end
    send(6'b100111, 1'b1, -1);

    // Continuous load with alternating words
    alt[0] = 6'b000001;
    alt[1] = 6'b100000;
    @(negedge clk);
    din  = alt[0];
    dir  = 1'b1;
    load = 1'b1;
    push_exp(alt[0], 1'b1);
    for (int f = 0; f < 4; f++) begin
      @(posedge clk);
      for (int n = 0; n <= FL; n++) begin
        @(negedge clk);
        if (n == 0)
          check("cont_start", sframe, 1'b1);
        if (n == FL) begin
          check("cont_done", done, 1'b1);
          check("cont_ready", ready, 1'b1);
          if (f < 3) begin
            din = alt[(f + 1) % 2];
            dir = f[0];
            push_exp(din, dir);
          end else begin
            load = 1'b0;
          end
        end
      end
    end
    @(negedge clk);
    check("cont_stop", sframe, 1'b0);

    // A few random frames
    for (int i = 0; i < 4; i++)
      send(W'($urandom), 1'($urandom_range(0, 1)), -1);

    repeat (3) @(negedge clk);
    check("sb_empty", exp_q.size(), 0);
    check("frame_count", n_frames, n_pushed - 1);  // the cleared frame never completes

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/parallel_serializer.md
# parallel_serializer

Parallel-in, serial-out transmit stage that sits directly upstream of the 6-bit serial shift-register family (right/left shift, ring, twisted, serial-to-parallel). Accepts one parallel word per handshake and drives it bit-by-bit onto a serial line consumed by those registers' `data` input, one bit per clock. It owns framing, the bit counter and the optional parity bit.

## Interface
- `WIDTH`, 6: word width in bits and frame length without parity; legal range 2..16.
- `clk`  input  1  clock; all state changes on the rising edge.
- `clr`  input  1  reset, asynchronous, active-high.
- `din`  input  WIDTH  parallel word; sampled only when a load is accepted.
- `load`  input  1  request to start a frame; accepted only while `ready`=1.
- `dir`  input  1  bit order, sampled with `din`: 0 = LSB first, 1 = MSB first.
- `ready`  output  1  high in IDLE; a load is accepted on any edge where `load` and `ready` are both 1.
- `sout`  output  1  serial data bit; connects to the downstream register's `data`.
- `sframe`  output  1  high while `sout` carries a valid frame bit.
- `done`  output  1  one-cycle pulse after the last frame bit.

## Operation
- All outputs registered. Reset values: `sout`=0, `sframe`=0, `ready`=1, `done`=0; internal shift register, bit counter and stored `dir` cleared to 0; state IDLE.
- States: IDLE, SHIFT, PAR (PAR exists only with the parity option).
- IDLE: `ready`=1, `sframe`=0, `sout`=0. On an edge with `load`=1: capture `din` and `dir`, counter := 0, go to SHIFT, drive the first bit (`din[0]` if `dir`=0, `din[WIDTH-1]` if `dir`=1), `sframe`:=1, `ready`:=0.
- SHIFT: each edge advances one bit in the captured order and increments the counter. When the counter reaches WIDTH-1 at an edge, leave SHIFT: go to PAR with parity, otherwise go to IDLE.
- PAR: `sout` = even-parity bit (XOR of the captured word), `sframe`=1; next edge goes to IDLE.
- Entering IDLE from SHIFT/PAR: `sframe`:=0, `sout`:=0, `ready`:=1, `done`:=1 for exactly one cycle.
- `load` while `ready`=0 is ignored; `din`/`dir` changes mid-frame have no effect.
- `load` held high continuously: a new frame is accepted on the edge following the `done` edge.
- `clr` asserted in any state, including mid-frame: outputs go to reset values immediately, the frame is aborted, no `done` is produced. The first load is accepted on the first edge after `clr` deasserts.

## Timing
- Edge E0 accepts the load. Bit k (k = 0..WIDTH-1) is on `sout` from edge E0+k to edge E0+k+1.
- Without parity: `done`=1 and `ready`=1 from E0+WIDTH to E0+WIDTH+1. The frame period under continuous load is WIDTH+1 cycles (7 at the default width).
- With parity: the parity bit is on `sout` from E0+WIDTH to E0+WIDTH+1. `done` is high from E0+WIDTH+1; the period is WIDTH+2 cycles.
- The downstream serial-to-parallel register holds the complete word on the edge that raises `done`. It should qualify its capture with `done`.

## Configuration
- `SERIALIZER_PARITY_EN` defined: PAR state compiled in; every frame is WIDTH+1 bits, ending with the even-parity bit.
- Not defined: no PAR state and no parity logic; frames are exactly WIDTH bits.

## Test plan
- Load `din`=6'b101100, `dir`=1, no parity. `sout` on E0..E5 must be 1,0,1,1,0,0 with `sframe`=1 throughout. At E6: `done`=1, `ready`=1, `sframe`=0.
- Load the same word with `dir`=0. `sout` must be 0,0,1,1,0,1.
- With `SERIALIZER_PARITY_EN`, load 6'b101100, `dir`=1. Expect the same six bits, then parity 1 at E6, `done` at E7. Load 6'b110000: parity 0.
- Pulse `load` with `din`=6'b111111 at E2 of a frame already in progress. The frame continues unchanged, no second frame starts, and `ready` stays 0 until `done`.
- Assert `clr` asynchronously mid-cycle after E2. `sout`=0, `sframe`=0 and `ready`=1 immediately; no `done` ever appears for that frame. A new load after release transmits correctly.
- Hold `load`=1 with alternating words 6'b000001 and 6'b100000. Frames must start every 7 cycles (8 with parity), each followed by one `done` pulse.
- Chain into the serial-to-parallel register. At each `done`, its outputs a..f must equal the loaded word in the order set by `dir`.
